// File: rtl/spart_pkg.sv
// Shared SPART types and limits for the transmitter and receiver.
package spart_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} tx_state_t;

  localparam logic IDLE_LEVEL  = 1'b1;
  localparam logic START_LEVEL = 1'b0;

  localparam int MIN_DATA_BITS  = 5;
  localparam int MAX_DATA_BITS  = 9;
  localparam int MIN_STOP_BITS  = 1;
  localparam int MAX_STOP_BITS  = 2;
  localparam int MAX_FIFO_DEPTH = 16;

  // Wide enough to count 0..MAX_DATA_BITS inclusive.
  localparam int BIT_CNT_W = $clog2(MAX_DATA_BITS + 1);

endpackage

// File: rtl/spart_sync_fifo.sv
// Single-clock FIFO with occupancy count; a push while full is taken only if a pop frees a slot.
module spart_sync_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [AW-1:0]               wr_ptr, rd_ptr;
  logic                        do_push, do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/spart_tx_fifo.sv
// SPART transmitter: write FIFO feeding an LSB-first serialiser paced by tx_enable.
// Optional parity bit under `define SPART_TX_PARITY_EN (adds input parity_odd).
module spart_tx_fifo import spart_pkg::*; #(
  parameter  int DATA_BITS  = 8,
  parameter  int STOP_BITS  = 1,
  parameter  int FIFO_DEPTH = 4,
  localparam int CW         = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tx_enable,
  input  logic                 write,
  input  logic [DATA_BITS-1:0] tx_in,
`ifdef SPART_TX_PARITY_EN
  input  logic                 parity_odd,
`endif
  output logic                 txd,
  output logic                 tbr,
  output logic                 tx_busy,
  output logic [CW-1:0]        fifo_count,
  output logic                 ovf,
  input  logic                 clr_ovf
);

  tx_state_t              state, state_n;
  logic                   txd_n;
  logic [DATA_BITS-1:0]   shreg, sh_n;
  logic [BIT_CNT_W-1:0]   bit_cnt, bit_cnt_n;
  logic [1:0]             stop_cnt, stop_cnt_n;
  logic                   pop, load;
  logic [DATA_BITS-1:0]   fifo_dout;
  logic                   fifo_full, fifo_empty;
`ifdef SPART_TX_PARITY_EN
  logic                   par_q, par_n;
`endif

  spart_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (write),
    .pop   (pop),
    .din   (tx_in),
    .dout  (fifo_dout),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign tbr     = !fifo_full;
  assign tx_busy = (state != IDLE) || !fifo_empty;

  always_comb begin
    state_n    = state;
    txd_n      = txd;
    sh_n       = shreg;
    bit_cnt_n  = bit_cnt;
    stop_cnt_n = stop_cnt;
    load       = 1'b0;
    pop        = 1'b0;
`ifdef SPART_TX_PARITY_EN
    par_n      = par_q;
`endif
    if (tx_enable) begin
      case (state)
        IDLE: load = !fifo_empty;
        START: begin
          txd_n     = shreg[0];
          sh_n      = shreg >> 1;
          bit_cnt_n = BIT_CNT_W'(1);
          state_n   = DATA;
        end
        DATA: begin
          if (bit_cnt < BIT_CNT_W'(DATA_BITS)) begin
            txd_n     = shreg[0];
            sh_n      = shreg >> 1;
            bit_cnt_n = bit_cnt + BIT_CNT_W'(1);
          end else begin
`ifdef SPART_TX_PARITY_EN
            txd_n      = par_q;
            state_n    = PAR;
`else
            txd_n      = IDLE_LEVEL;
            stop_cnt_n = 2'd1;
            state_n    = STOP;
`endif
          end
        end
`ifdef SPART_TX_PARITY_EN
        PAR: begin
          txd_n      = IDLE_LEVEL;
          stop_cnt_n = 2'd1;
          state_n    = STOP;
        end
`endif
        STOP: begin
          if (stop_cnt == 2'(STOP_BITS)) begin
            // Last stop period: chain straight into the next frame if one is queued.
            load = !fifo_empty;
            if (fifo_empty) begin
              txd_n   = IDLE_LEVEL;
              state_n = IDLE;
            end
          end else begin
            stop_cnt_n = stop_cnt + 2'd1;
          end
        end
        default: state_n = IDLE;
      endcase
    end
    if (load) begin
      pop     = 1'b1;
      sh_n    = fifo_dout;
      txd_n   = START_LEVEL;
      state_n = START;
`ifdef SPART_TX_PARITY_EN
      par_n   = (^fifo_dout) ^ parity_odd;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      txd      <= IDLE_LEVEL;
      shreg    <= '0;
      bit_cnt  <= '0;
      stop_cnt <= '0;
`ifdef SPART_TX_PARITY_EN
      par_q    <= 1'b0;
`endif
    end else begin
      state    <= state_n;
      txd      <= txd_n;
      shreg    <= sh_n;
      bit_cnt  <= bit_cnt_n;
      stop_cnt <= stop_cnt_n;
`ifdef SPART_TX_PARITY_EN
      par_q    <= par_n;
`endif
    end
  end

  // A write while full is dropped unless the serialiser pops in the same cycle.
  always_ff @(posedge clk) begin
    if (rst)                        ovf <= 1'b0;
    else if (write && fifo_full && !pop) ovf <= 1'b1;
    else if (clr_ovf)               ovf <= 1'b0;
  end

endmodule

// File: tb/tb_spart_tx_fifo.sv
// Random + directed bench for spart_tx_fifo: 8N1 and 7-data/2-stop instances against a queue model.
module tb_spart_tx_fifo;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic       clk = 1'b0, rst = 1'b1, tx_enable = 1'b0, write = 1'b0, clr_ovf = 1'b0;
  logic [8:0] tx_in = '0;
`ifdef SPART_TX_PARITY_EN
  logic       parity_odd = 1'b0;
`endif
  bit         chk_en = 1'b0;
  int         n_tests = 0, n_fail = 0;

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : cfg
    localparam int DB = (g == 0) ? 8 : 7;
    localparam int SB = (g == 0) ? 1 : 2;

    logic          txd, tbr, tx_busy, ovf;
    logic [CW-1:0] fifo_count;

    spart_tx_fifo #(.DATA_BITS(DB), .STOP_BITS(SB), .FIFO_DEPTH(DEPTH)) dut (
      .clk        (clk),
      .rst        (rst),
      .tx_enable  (tx_enable),
      .write      (write),
      .tx_in      (tx_in[DB-1:0]),
`ifdef SPART_TX_PARITY_EN
      .parity_odd (parity_odd),
`endif
      .txd        (txd),
      .tbr        (tbr),
      .tx_busy    (tx_busy),
      .fifo_count (fifo_count),
      .ovf        (ovf),
      .clr_ovf    (clr_ovf)
    );

    // Model: queue of pending words, queue of line levels left in the current frame.
    int q[$];
    bit rem[$];
    bit busy_m = 1'b0, txd_m = 1'b1, ovf_m = 1'b0;

    initial forever begin
      int  d;
      bit  dropped;
      @(posedge clk);
      if (rst) begin
        q.delete(); rem.delete();
        busy_m = 1'b0; txd_m = 1'b1; ovf_m = 1'b0;
      end else begin
        if (tx_enable) begin
          if (rem.size() > 0) txd_m = rem.pop_front();
          else if (q.size() > 0) begin
            d = q.pop_front();
            txd_m = 1'b0; busy_m = 1'b1;
            for (int i = 0; i < DB; i++) rem.push_back(d[i]);
`ifdef SPART_TX_PARITY_EN
            rem.push_back((^d[DB-1:0]) ^ parity_odd);
`endif
            for (int i = 0; i < SB; i++) rem.push_back(1'b1);
          end else begin
            txd_m = 1'b1; busy_m = 1'b0;
          end
        end
        dropped = 1'b0;
        if (write) begin
          if (q.size() < DEPTH) q.push_back(int'(tx_in[DB-1:0]));
          else dropped = 1'b1;
        end
        if (dropped) ovf_m = 1'b1;
        else if (clr_ovf) ovf_m = 1'b0;
      end
    end

    initial forever begin
      @(negedge clk);
      if (chk_en) begin
        chk($sformatf("c%0d.txd", g),   txd,        txd_m);
        chk($sformatf("c%0d.tbr", g),   tbr,        q.size() != DEPTH);
        chk($sformatf("c%0d.busy", g),  tx_busy,    busy_m || (q.size() != 0));
        chk($sformatf("c%0d.count", g), fifo_count, q.size());
        chk($sformatf("c%0d.ovf", g),   ovf,        ovf_m);
      end
    end
  end

  task automatic step(input bit w, input logic [8:0] d, input bit t, input bit c, input bit r);
    @(posedge clk); #1;
    write = w; tx_in = d; tx_enable = t; clr_ovf = c; rst = r;
`ifdef SPART_TX_PARITY_EN
    parity_odd = $urandom_range(0, 1);
`endif
  endtask

  initial begin
    @(posedge clk); #1;
    chk_en = 1'b1;
    repeat (2) step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0);

    // Single 0x22 frame, tick every 10 clocks.
    step(1, 9'h22, 0, 0, 0);
    for (int k = 0; k < 12; k++) begin
      step(0, 0, 1, 0, 0);
      repeat (9) step(0, 0, 0, 0, 0);
    end

    // Fill FIFO, overflow write, clear, then drain back-to-back.
    step(1, 9'h0A5, 0, 0, 0);
    step(1, 9'h03C, 0, 0, 0);
    step(1, 9'h0FF, 0, 0, 0);
    step(1, 9'h000, 0, 0, 0);
    step(1, 9'h011, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0);
    for (int k = 0; k < 50; k++) begin
      step(0, 0, 1, 0, 0);
      repeat (2) step(0, 0, 0, 0, 0);
    end

    // Reset mid-frame with entries queued, then a clean frame.
    step(1, 9'h0C3, 0, 0, 0);
    step(1, 9'h05A, 0, 0, 0);
    step(1, 9'h0E1, 0, 0, 0);
    for (int k = 0; k < 5; k++) begin
      step(0, 0, 1, 0, 0);
      step(0, 0, 0, 0, 0);
    end
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0);
    step(1, 9'h041, 0, 0, 0);
    for (int k = 0; k < 14; k++) begin
      step(0, 0, 1, 0, 0);
      step(0, 0, 0, 0, 0);
    end

    // Random traffic, including writes on pop cycles while full.
    for (int k = 0; k < 4000; k++)
      step($urandom_range(0, 99) < 35, 9'($urandom), $urandom_range(0, 99) < 30,
           $urandom_range(0, 99) < 5, $urandom_range(0, 299) == 0);

    step(0, 0, 0, 0, 0);
    @(posedge clk); #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
